bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
Parametrised multi-digit decimal (BCD) counter. It is the successor to the single-digit counter and keeps the count strictly within 0-9 per digit. Adds N digits, up/down counting, synchronous clear and parallel load, a terminal-count output for cascading, and a registered wrap pulse. It sits behind the display/timer logic and feeds the 7-segment decoders one nibble per digit.

Parameters:
DIGITS, 4, number of BCD digits; counter range 0 to 10^DIGITS-1.
INIT, 0, reset/clear value as a plain binary integer < 10^DIGITS, converted to BCD at elaboration.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
clr  in  1  synchronous clear to INIT.
load  in  1  synchronous parallel load of load_val.
load_val  in  4*DIGITS  BCD value to load; digit k is bits [4k+3:4k], digit 0 is least significant.
en  in  1  count enable; one step per clk while high.
up  in  1  direction: 1 = increment, 0 = decrement.
count  out  4*DIGITS  current BCD value, same digit packing as load_val.
tc  out  1  terminal count, combinational.
wrap  out  1  registered one-cycle pulse on wrap-around.
load_err  out  1  registered one-cycle pulse when load_val contained a digit > 9.

Behaviour:
- Reset: reset=0 asynchronously forces count=INIT (BCD), wrap=0, load_err=0. Reset asserted mid-count takes effect immediately, with no wait for clk.
- Priority per cycle: clr > load > en. Only one action is taken per edge.
- clr=1: count<=INIT; wrap<=0; load_err<=0.
- load=1 (clr=0): each digit of load_val with value 0-9 is loaded as-is. Any digit with value 10-15 is loaded as 0, and load_err<=1 for exactly that cycle. wrap<=0. en is ignored that cycle.
- en=1, up=1 (no clr/load): BCD increment. Digit k increments when all lower digits were 9. A digit at 9 that increments becomes 0. All digits at 9 -> count becomes all 0 and wrap<=1.
- en=1, up=0: BCD decrement. Digit k decrements when all lower digits were 0. A digit at 0 that decrements becomes 9. All digits at 0 -> count becomes all 9 and wrap<=1.
- en=0 (no clr/load): count holds; wrap<=0; load_err<=0.
- wrap and load_err are high only in the cycle immediately after the causing edge. They are never high two consecutive cycles unless the cause repeats.
- tc = en & (up ? count==all-9 : count==all-0). It is purely combinational and asserts in the same cycle as the state that will wrap, so an enable can be chained to the next counter stage.
- Changing up while counting takes effect on the next edge, with no extra latency.
- Count latency: count reflects an action 1 cycle after the qualifying edge; it is a register output with no combinational path from inputs.
- Invariant: no digit of count ever holds 10-15 under any input sequence.
- Arithmetic is per-digit 4-bit with carry/borrow chaining; no binary-to-BCD conversion at run time.

Test Plan:
- Reset then count up, DIGITS=2, INIT=0: en=1, up=1 for 100 cycles -> count 00, 01 ... 09, 10 ... 99, 00; wrap high only on the cycle count shows 00 after 99; tc high while count=99.
- Decrement wrap: load 0x00, en=1, up=0 for one cycle -> count=0x99, wrap=1 for one cycle; tc was 1 in the cycle before.
- Digit borrow: load 0x10, up=0, en=1 for 1 cycle -> 0x09; load 0x19, up=1 -> 0x20.
- Invalid load: load_val=0xA7 -> count=0x07, load_err=1 for one cycle only; digit never reads A-F afterwards.
- Priority: clr=1, load=1, en=1 on the same edge with INIT=42 -> count=0x42; load=1 with en=1 -> loaded value, no increment.
- Async reset mid-count: reset pulled low between edges at count=0x57 -> count=INIT immediately with no clk edge; wrap and load_err=0; counting resumes correctly from INIT on the first edge after release.

Source files
------------

// File: rtl/bcd_counter_n_if.sv
// ---------------------------------------------------------------------------
// bcd_counter_n_if
// Control and status bundle for the multi-digit BCD counter.
//   clr       : synchronous clear to the INIT value
//   load      : synchronous parallel load of load_val
//   load_val  : BCD value to load, digit k in bits [4k+3:4k]
//   en        : count enable, one step per clock
//   up        : direction, 1 = increment, 0 = decrement
//   count     : current BCD value, same packing as load_val
//   tc        : combinational terminal count (next enabled step wraps)
//   wrap      : registered one-cycle pulse after a wrap-around
//   load_err  : registered one-cycle pulse after a load with a digit > 9
// master = the controlling logic, slave = the counter.
// ---------------------------------------------------------------------------
interface bcd_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
// Parametrised DIGITS-digit decimal counter with up/down counting,
// synchronous clear and parallel load, terminal count for cascading and
// registered wrap / load-error pulses. Every digit stays within 0-9.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-low reset, forces count to INIT
//   bus    : bcd_counter_n_if slave modport (controls and status)
// Parameters:
//   DIGITS : number of BCD digits
//   INIT   : reset/clear value as a binary integer < 10**DIGITS
// ---------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter int INIT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    bcd_counter_n_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    // Elaboration-time binary to BCD conversion of INIT.
    function automatic logic [W-1:0] toBcd(input int value);
        int           v;
        logic [W-1:0] r;
        v = value;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] INIT_BCD = toBcd(INIT);

    logic [W-1:0] r_count;
    logic         r_wrap;
    logic         r_loadErr;

    logic [W-1:0] w_incVal;
    logic [W-1:0] w_decVal;
    logic [W-1:0] w_loadVal;
    logic         w_allNine;
    logic         w_allZero;
    logic         w_loadBad;

    // Ripple carry/borrow chain: a digit moves only when every lower digit
    // was at its limit. The final carry/borrow doubles as the all-9 / all-0
    // detect used for tc and wrap.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        logic [3:0] ld;
        w_incVal  = '0;
        w_decVal  = '0;
        w_loadVal = '0;
        w_loadBad = 1'b0;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = r_count[4*k +: 4];
            if (carry) begin
                w_incVal[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
            end else begin
                w_incVal[4*k +: 4] = d;
            end
            if (borrow) begin
                w_decVal[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            end else begin
                w_decVal[4*k +: 4] = d;
            end
            carry  = carry  & (d == 4'd9);
            borrow = borrow & (d == 4'd0);

            // Non-decimal digits load as 0 and flag the error.
            ld = bus.load_val[4*k +: 4];
            if (ld > 4'd9) begin
                w_loadVal[4*k +: 4] = 4'd0;
                w_loadBad           = 1'b1;
            end else begin
                w_loadVal[4*k +: 4] = ld;
            end
        end
        w_allNine = carry;
        w_allZero = borrow;
    end

    // Count register with clr > load > en priority; wrap and load_err are
    // rewritten every edge so they never stretch beyond one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= INIT_BCD;
            r_wrap    <= 1'b0;
            r_loadErr <= 1'b0;
        end else if (bus.clr) begin
            r_count   <= INIT_BCD;
            r_wrap    <= 1'b0;
            r_loadErr <= 1'b0;
        end else if (bus.load) begin
            r_count   <= w_loadVal;
            r_wrap    <= 1'b0;
            r_loadErr <= w_loadBad;
        end else if (bus.en) begin
            r_loadErr <= 1'b0;
            if (bus.up) begin
                r_count <= w_incVal;
                r_wrap  <= w_allNine;
            end else begin
                r_count <= w_decVal;
                r_wrap  <= w_allZero;
            end
        end else begin
            r_wrap    <= 1'b0;
            r_loadErr <= 1'b0;
        end
    end

    assign bus.count    = r_count;
    assign bus.tc       = bus.en & (bus.up ? w_allNine : w_allZero);
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_loadErr;
endmodule

// File: tb/tb_bcd_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_n
// Self-checking bench for a 2-digit bcd_counter_n with INIT = 42.
// An integer-valued reference model tracks the expected count; a negedge
// compare process checks every output each cycle, and directed sections
// pin specific literal values. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_bcd_counter_n;
    localparam int DIGITS = 2;
    localparam int INIT   = 42;
    localparam int MODV   = 100;
    localparam int MAXV   = MODV - 1;

    logic clk;
    logic reset;
    bit   checking;
    int   nTests;
    int   nFail;

    int   mVal  = INIT;
    bit   mWrap = 1'b0;
    bit   mErr  = 1'b0;

    bcd_counter_n_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter_n #(.DIGITS(DIGITS), .INIT(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Decimal value the counter holds after a load; bad digits become 0.
    function automatic int loadValue(input logic [7:0] lv);
        int hi;
        int lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi > 9) hi = 0;
        if (lo > 9) lo = 0;
        return hi * 10 + lo;
    endfunction

    function automatic bit loadBad(input logic [7:0] lv);
        return (lv[7:4] > 4'd9) || (lv[3:0] > 4'd9);
    endfunction

    // Reference model: count as a plain integer modulo 100.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mVal  <= INIT;
            mWrap <= 1'b0;
            mErr  <= 1'b0;
        end else if (bus.clr) begin
            mVal  <= INIT;
            mWrap <= 1'b0;
            mErr  <= 1'b0;
        end else if (bus.load) begin
            mVal  <= loadValue(bus.load_val);
            mWrap <= 1'b0;
            mErr  <= loadBad(bus.load_val);
        end else if (bus.en) begin
            mErr <= 1'b0;
            if (bus.up) begin
                mWrap <= (mVal == MAXV);
                mVal  <= (mVal + 1) % MODV;
            end else begin
                mWrap <= (mVal == 0);
                mVal  <= (mVal + MODV - 1) % MODV;
            end
        end else begin
            mWrap <= 1'b0;
            mErr  <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("count", 32'(bus.count), 32'(toBcd(mVal)));
            checkOutput("tc", 32'(bus.tc),
                        32'(bus.en && (bus.up ? (mVal == MAXV) : (mVal == 0))));
            checkOutput("wrap", 32'(bus.wrap), 32'(mWrap));
            checkOutput("load_err", 32'(bus.load_err), 32'(mErr));
        end
    end

    task automatic setInputs(input bit c, input bit l, input logic [7:0] lv,
                             input bit e, input bit u);
        bus.clr      = c;
        bus.load     = l;
        bus.load_val = lv;
        bus.en       = e;
        bus.up       = u;
    endtask

    // Called just after a rising edge; returns just after the edge that
    // applied these inputs, so outputs show the result.
    task automatic applyStimulus(input bit c, input bit l, input logic [7:0] lv,
                                 input bit e, input bit u);
        setInputs(c, l, lv, e, u);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nTests   = 0;
        nFail    = 0;
        checking = 1'b0;
        reset    = 1'b1;
        setInputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        checking = 1'b1;

        checkOutput("reset_count", 32'(bus.count), 32'h42);
        checkOutput("reset_wrap", 32'(bus.wrap), 32'h0);
        checkOutput("reset_err", 32'(bus.load_err), 32'h0);

        // Count up from 00 through 99 and wrap.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput("load_00", 32'(bus.count), 32'h00);
        for (int i = 1; i <= 101; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            if (i == 9)   checkOutput("up_09", 32'(bus.count), 32'h09);
            if (i == 10)  checkOutput("up_10", 32'(bus.count), 32'h10);
            if (i == 99) begin
                checkOutput("up_99", 32'(bus.count), 32'h99);
                checkOutput("up_tc99", 32'(bus.tc), 32'h1);
                checkOutput("up_nowrap99", 32'(bus.wrap), 32'h0);
            end
            if (i == 100) begin
                checkOutput("up_wrap00", 32'(bus.count), 32'h00);
                checkOutput("up_wrap", 32'(bus.wrap), 32'h1);
            end
            if (i == 101) checkOutput("up_wrap_once", 32'(bus.wrap), 32'h0);
        end

        // Decrement wrap from 00 to 99, with tc seen beforehand.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        setInputs(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("dn_tc00", 32'(bus.tc), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("dn_wrap99", 32'(bus.count), 32'h99);
        checkOutput("dn_wrap", 32'(bus.wrap), 32'h1);

        // Digit borrow and carry.
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("borrow_09", 32'(bus.count), 32'h09);
        applyStimulus(1'b0, 1'b1, 8'h19, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("carry_20", 32'(bus.count), 32'h20);

        // Invalid load digit.
        applyStimulus(1'b0, 1'b1, 8'hA7, 1'b0, 1'b1);
        checkOutput("bad_load_val", 32'(bus.count), 32'h07);
        checkOutput("bad_load_err", 32'(bus.load_err), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("bad_load_hold", 32'(bus.count), 32'h07);
        checkOutput("bad_load_once", 32'(bus.load_err), 32'h0);

        // Priority clr > load > en.
        applyStimulus(1'b1, 1'b1, 8'h13, 1'b1, 1'b1);
        checkOutput("prio_clr", 32'(bus.count), 32'h42);
        applyStimulus(1'b0, 1'b1, 8'h19, 1'b1, 1'b1);
        checkOutput("prio_load", 32'(bus.count), 32'h19);

        // Asynchronous reset between edges at 57.
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("pre_reset_57", 32'(bus.count), 32'h57);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_count", 32'(bus.count), 32'h42);
        checkOutput("async_wrap", 32'(bus.wrap), 32'h0);
        checkOutput("async_err", 32'(bus.load_err), 32'h0);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resume_43", 32'(bus.count), 32'h43);

        // Randomized phase, checked by the per-cycle compare process.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        end

        setInputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
